jtag_top: RTL and testbench
===========================

JTAG_TOP -- requirements
Module: jtag_top

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 iTck  input  1  test clock; sole clock, all state changes on rising edge except REQ-019.
REQ-003 iTrst  input  1  synchronous active-high reset, sampled on rising iTck.
REQ-004 iTms  input  1  test mode select, sampled on rising iTck.
REQ-005 iTdi  input  1  serial test data in, sampled on rising iTck.
REQ-006 iDesync  input  1  synchronous pulse; clears config sync state.
REQ-007 oTdo  output  1  serial test data out.
REQ-008 oTdoEnable  output  1  high while oTdo carries valid shift data.
REQ-009 oWrEn  output  1  one-cycle config write strobe.
REQ-010 oCfgData  output  8  last accepted config word.

Function
REQ-011 TAP FSM SHALL implement the 16 IEEE 1149.1 states (Test-Logic-Reset, Run-Test/Idle, Select-DR/IR, Capture, Shift, Exit1, Pause, Exit2, Update for DR and IR) with standard iTms transitions.
REQ-012 Five consecutive iTms=1 cycles SHALL reach Test-Logic-Reset from any state.
REQ-013 IR SHALL be 4 bits; Capture-IR loads 4'b0001; Shift-IR shifts right, iTdi into MSB, LSB to oTdo; Update-IR copies the shift register to the active instruction.
REQ-014 Opcodes: 4'b0001 BYPASS, 4'b0010 IDCODE, 4'b0100 CONFIG; every other code SHALL select BYPASS.
REQ-015 Active instruction SHALL be IDCODE in Test-Logic-Reset.
REQ-016 BYPASS DR: 1 bit, Capture-DR loads 0, Shift-DR passes iTdi through with exactly one cycle delay.
REQ-017 IDCODE DR: 32 bits, Capture-DR loads 32'h1234_5001 (bit0=1), Shift-DR shifts right, LSB first to oTdo, iTdi into bit31.
REQ-018 CONFIG DR: 8 bits, Shift-DR shifts right, iTdi into bit7, bit0 to oTdo; Capture-DR retains contents; after 8 shifts bit0 holds the first bit shifted.
REQ-019 oTdo and oTdoEnable SHALL update on falling iTck; oTdoEnable=1 only in Shift-IR or Shift-DR; otherwise oTdo=0.
REQ-020 Config sync flag: on Update-DR with CONFIG active, if flag=0 and CONFIG DR==8'hF0 the flag SHALL be set; if flag=0 and DR!=8'hF0 nothing happens.
REQ-021 On Update-DR with CONFIG active and flag=1: oCfgData<=DR and oWrEn=1 for exactly that one cycle; flag stays set.
REQ-022 iDesync=1 SHALL clear the flag on the next rising edge; if coincident with Update-DR, desync wins and no oWrEn is issued.
REQ-023 Test-Logic-Reset SHALL also clear the flag; oCfgData retains its value.
REQ-024 Shift lengths other than the nominal width SHALL be accepted; Update uses whatever the register holds.

Reset
REQ-025 iTrst=1 SHALL force Test-Logic-Reset, instruction=IDCODE, IR shift=4'b0001, DR registers=0, flag=0, oCfgData=8'h00, oWrEn=0, oTdo=0, oTdoEnable=0.
REQ-026 Reset mid-shift SHALL abort the shift; no Update action occurs.

Structure
REQ-027 Shared package jtag_pkg SHALL hold TAP state enum, opcode constants, IDCODE value 32'h1234_5001 and sync word 8'hF0.
REQ-028 TAP state machine SHALL be a sub-module jtag_tap_fsm (iTck, iTrst, iTms -> state); data registers and config logic stay in jtag_top.

Verification
REQ-029 Reset, then load IR 4'b0001, shift DR pattern 8'b00111100 LSB first -> oTdo shows 0 then the pattern delayed one cycle, oTdoEnable high during shift.
REQ-030 Load IR 4'b0010, shift 32 bits of DR -> oTdo emits 32'h1234_5001 LSB first.
REQ-031 Load IR 4'b0100, shift 8'hF0 then Update, then shift 8'h01 and Update -> oWrEn one cycle, oCfgData=8'h01.
REQ-032 CONFIG, shift 8'hA4 without prior sync word -> no oWrEn; oCfgData unchanged.
REQ-033 Sync with 8'hF0, pulse iDesync, shift 8'h55 + Update -> no oWrEn; repeat sync+data loop for values 1..255 -> 255 strobes with matching oCfgData.
REQ-034 Hold iTms=1 for 5 cycles from Shift-DR -> Test-Logic-Reset, instruction=IDCODE, flag cleared.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes, register widths and constants.
package jtag_pkg;

  localparam int unsigned IR_W  = 4;
  localparam int unsigned ID_W  = 32;
  localparam int unsigned CFG_W = 8;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR        = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR        = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_e;

  localparam logic [IR_W-1:0]  OP_BYPASS  = 4'b0001;
  localparam logic [IR_W-1:0]  OP_IDCODE  = 4'b0010;
  localparam logic [IR_W-1:0]  OP_CONFIG  = 4'b0100;
  localparam logic [IR_W-1:0]  IR_CAPTURE = 4'b0001;

  localparam logic [ID_W-1:0]  IDCODE_VAL = 32'h1234_5001;
  localparam logic [CFG_W-1:0] SYNC_WORD  = 8'hF0;

  // Unknown opcodes collapse to BYPASS so the active instruction is always one of three.
  function automatic logic [IR_W-1:0] decode_ir(input logic [IR_W-1:0] code);
    if (code == OP_IDCODE || code == OP_CONFIG) begin
      return code;
    end
    return OP_BYPASS;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller.
// Ports: iTck (clock), iTrst (sync active-high reset), iTms (mode select),
//        oState (current TAP state, registered).
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       iTck,
  input  logic       iTrst,
  input  logic       iTms,
  output tap_state_e oState
);

  tap_state_e state_q;
  tap_state_e state_d;

  // Standard TMS-driven next-state table.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TEST_LOGIC_RESET: state_d = iTms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = iTms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_d = iTms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_d = iTms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = iTms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = iTms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = iTms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = iTms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = iTms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_d = iTms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = iTms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = iTms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = iTms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = iTms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = iTms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = iTms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  always_ff @(posedge iTck) begin
    if (iTrst) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign oState = state_q;

endmodule

// File: rtl/jtag_top.sv
// JTAG TAP with BYPASS / IDCODE / CONFIG data registers and a sync-word gated
// configuration write port.
// Ports: iTck, iTrst (sync active-high reset), iTms, iTdi, iDesync (clears sync),
//        oTdo / oTdoEnable (falling-edge serial out), oWrEn (1-cycle strobe),
//        oCfgData (last accepted config word).
module jtag_top
  import jtag_pkg::*;
(
  input  logic             iTck,
  input  logic             iTrst,
  input  logic             iTms,
  input  logic             iTdi,
  input  logic             iDesync,
  output logic             oTdo,
  output logic             oTdoEnable,
  output logic             oWrEn,
  output logic [CFG_W-1:0] oCfgData
);

  tap_state_e state;

  jtag_tap_fsm u_tap_fsm (
    .iTck   (iTck),
    .iTrst  (iTrst),
    .iTms   (iTms),
    .oState (state)
  );

  logic [IR_W-1:0]  ir_shift_q,  ir_shift_d;
  logic [IR_W-1:0]  ir_q,        ir_d;
  logic             bypass_q,    bypass_d;
  logic [ID_W-1:0]  idcode_q,    idcode_d;
  logic [CFG_W-1:0] cfg_dr_q,    cfg_dr_d;
  logic             sync_q,      sync_d;
  logic [CFG_W-1:0] cfg_data_q,  cfg_data_d;
  logic             wr_en_q,     wr_en_d;
  logic             tdo_q,       tdo_d;
  logic             tdo_en_q,    tdo_en_d;

  // Instruction, data register and config-sync next-state logic.
  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    cfg_dr_d   = cfg_dr_q;
    sync_d     = sync_q;
    cfg_data_d = cfg_data_q;
    wr_en_d    = 1'b0;

    unique case (state)
      TEST_LOGIC_RESET: begin
        ir_d   = OP_IDCODE;
        sync_d = 1'b0;
      end
      CAPTURE_IR: ir_shift_d = IR_CAPTURE;
      SHIFT_IR:   ir_shift_d = {iTdi, ir_shift_q[IR_W-1:1]};
      UPDATE_IR:  ir_d       = decode_ir(ir_shift_q);
      CAPTURE_DR: begin
        // CONFIG deliberately keeps its contents across capture.
        if (ir_q == OP_IDCODE) begin
          idcode_d = IDCODE_VAL;
        end else if (ir_q != OP_CONFIG) begin
          bypass_d = 1'b0;
        end
      end
      SHIFT_DR: begin
        if (ir_q == OP_IDCODE) begin
          idcode_d = {iTdi, idcode_q[ID_W-1:1]};
        end else if (ir_q == OP_CONFIG) begin
          cfg_dr_d = {iTdi, cfg_dr_q[CFG_W-1:1]};
        end else begin
          bypass_d = iTdi;
        end
      end
      UPDATE_DR: begin
        if (ir_q == OP_CONFIG && !iDesync) begin
          if (sync_q) begin
            cfg_data_d = cfg_dr_q;
            wr_en_d    = 1'b1;
          end else if (cfg_dr_q == SYNC_WORD) begin
            sync_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Desync overrides any sync or write decision made above.
    if (iDesync) begin
      sync_d = 1'b0;
    end
  end

  // Serial output mux; forced low outside the shift states and while in reset.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (!iTrst) begin
      if (state == SHIFT_IR) begin
        tdo_d    = ir_shift_q[0];
        tdo_en_d = 1'b1;
      end else if (state == SHIFT_DR) begin
        tdo_en_d = 1'b1;
        if (ir_q == OP_IDCODE) begin
          tdo_d = idcode_q[0];
        end else if (ir_q == OP_CONFIG) begin
          tdo_d = cfg_dr_q[0];
        end else begin
          tdo_d = bypass_q;
        end
      end
    end
  end

  always_ff @(posedge iTck) begin
    if (iTrst) begin
      ir_shift_q <= IR_CAPTURE;
      ir_q       <= OP_IDCODE;
      bypass_q   <= 1'b0;
      idcode_q   <= '0;
      cfg_dr_q   <= '0;
      sync_q     <= 1'b0;
      cfg_data_q <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      ir_q       <= ir_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
      cfg_dr_q   <= cfg_dr_d;
      sync_q     <= sync_d;
      cfg_data_q <= cfg_data_d;
      wr_en_q    <= wr_en_d;
    end
  end

  // TDO launches on the falling edge so the host can sample it on the next rising edge.
  always_ff @(negedge iTck) begin
    tdo_q    <= tdo_d;
    tdo_en_q <= tdo_en_d;
  end

  assign oTdo       = tdo_q;
  assign oTdoEnable = tdo_en_q;
  assign oWrEn      = wr_en_q;
  assign oCfgData   = cfg_data_q;

endmodule

// File: tb/tb_jtag_top.sv
// Randomized self-checking bench for jtag_top against a transaction-level model.
module tb_jtag_top;

  logic       iTck = 1'b0;
  logic       iTrst = 1'b1;
  logic       iTms = 1'b1;
  logic       iTdi = 1'b0;
  logic       iDesync = 1'b0;
  logic       oTdo;
  logic       oTdoEnable;
  logic       oWrEn;
  logic [7:0] oCfgData;

  jtag_top dut (
    .iTck       (iTck),
    .iTrst      (iTrst),
    .iTms       (iTms),
    .iTdi       (iTdi),
    .iDesync    (iDesync),
    .oTdo       (oTdo),
    .oTdoEnable (oTdoEnable),
    .oWrEn      (oWrEn),
    .oCfgData   (oCfgData)
  );

  always #5 iTck = ~iTck;

  int n_checks = 0;
  int n_pass = 0;

  // Model state: active instruction, sync flag, config output and config DR.
  logic [3:0]  m_instr;
  logic        m_flag;
  logic [7:0]  m_cfg_data;
  logic [7:0]  m_cfg_dr;
  int          m_strobes = 0;
  int          obs_strobes = 0;
  logic [31:0] id_val = 32'h1234_5001;

  always @(negedge iTck) if (oWrEn === 1'b1) obs_strobes++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One TCK cycle: drive, sample serial out before the rising edge, settle after it.
  task automatic tick(input logic tms, input logic tdi, input logic des,
                      output logic tdo, output logic en);
    iTms = tms; iTdi = tdi; iDesync = des;
    @(negedge iTck); #1;
    tdo = oTdo; en = oTdoEnable;
    @(posedge iTck); #1;
  endtask

  task automatic model_reset();
    m_instr = 4'b0010; m_flag = 1'b0; m_cfg_data = 8'h00; m_cfg_dr = 8'h00;
  endtask

  function automatic logic [3:0] decode(input logic [3:0] c);
    return (c == 4'b0010 || c == 4'b0100) ? c : 4'b0001;
  endfunction

  task automatic model_update(input logic des, output logic wr);
    wr = 1'b0;
    if (m_instr == 4'b0100 && !des) begin
      if (m_flag) begin
        m_cfg_data = m_cfg_dr;
        wr = 1'b1;
      end else if (m_cfg_dr == 8'hF0) begin
        m_flag = 1'b1;
      end
    end
    if (des) m_flag = 1'b0;
  endtask

  task automatic scan_ir(input logic [3:0] op);
    logic t, e, en_all;
    logic [3:0] got;
    tick(1, 0, 0, t, e); tick(1, 0, 0, t, e); tick(0, 0, 0, t, e); tick(0, 0, 0, t, e);
    en_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, op[i], 0, t, e);
      got[i] = t;
      en_all &= e;
    end
    tick(1, 0, 0, t, e);
    chk("ir_exit_idle_out", 64'({t, e}), 64'(0));
    tick(0, 0, 0, t, e);
    chk("ir_capture_out", 64'(got), 64'(4'b0001));
    chk("ir_shift_en", 64'(en_all), 64'(1));
    m_instr = decode(op);
  endtask

  task automatic scan_dr(input int len, input logic [63:0] din, input logic des_upd);
    logic q[$];
    logic [63:0] got, exp;
    logic t, e, en_all, exp_wr;
    q = {};
    if (m_instr == 4'b0010) for (int i = 0; i < 32; i++) q.push_back(id_val[i]);
    else if (m_instr == 4'b0100) for (int i = 0; i < 8; i++) q.push_back(m_cfg_dr[i]);
    else q.push_back(1'b0);
    tick(1, 0, 0, t, e); tick(0, 0, 0, t, e); tick(0, 0, 0, t, e);
    chk("dr_capture_idle_out", 64'({t, e}), 64'(0));
    got = '0; exp = '0; en_all = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick(i == len - 1, din[i], 0, t, e);
      got[i] = t;
      en_all &= e;
      exp[i] = q.pop_front();
      q.push_back(din[i]);
    end
    tick(1, 0, 0, t, e);
    chk("dr_exit_idle_out", 64'({t, e}), 64'(0));
    tick(0, 0, des_upd, t, e);
    if (m_instr == 4'b0100) for (int i = 0; i < 8; i++) m_cfg_dr[i] = q[i];
    model_update(des_upd, exp_wr);
    chk("dr_tdo", got, exp);
    chk("dr_shift_en", 64'(en_all), 64'(1));
    chk("wr_strobe", 64'(oWrEn), 64'(exp_wr));
    chk("cfg_data", 64'(oCfgData), 64'(m_cfg_data));
    tick(0, 0, 0, t, e);
    chk("wr_one_cycle", 64'(oWrEn), 64'(0));
    if (exp_wr) m_strobes++;
  endtask

  // Enter Shift-DR, shift two bits, then hold TMS high for five cycles.
  task automatic tms5_from_shift(input logic [1:0] bits);
    logic t, e, wr;
    tick(1, 0, 0, t, e); tick(0, 0, 0, t, e); tick(0, 0, 0, t, e);
    tick(0, bits[0], 0, t, e);
    tick(1, bits[1], 0, t, e);
    if (m_instr == 4'b0100) begin
      m_cfg_dr = {bits[0], m_cfg_dr[7:1]};
      m_cfg_dr = {bits[1], m_cfg_dr[7:1]};
    end
    tick(1, 0, 0, t, e);
    tick(1, 0, 0, t, e);
    model_update(1'b0, wr);
    chk("tms5_update_wr", 64'(oWrEn), 64'(wr));
    if (wr) m_strobes++;
    tick(1, 0, 0, t, e); tick(1, 0, 0, t, e);
    m_instr = 4'b0010; m_flag = 1'b0;
    tick(0, 0, 0, t, e);
    chk("tlr_idle_out", 64'({t, e}), 64'(0));
    chk("tlr_cfg_kept", 64'(oCfgData), 64'(m_cfg_data));
  endtask

  initial begin
    logic t, e;
    logic [3:0] op;
    int r, len;
    logic [63:0] din;

    model_reset();
    iTrst = 1'b1;
    repeat (3) tick(1, 0, 0, t, e);
    chk("rst_tdo_en", 64'({t, e}), 64'(0));
    chk("rst_wr", 64'(oWrEn), 64'(0));
    chk("rst_cfg", 64'(oCfgData), 64'(0));
    iTrst = 1'b0;
    tick(0, 0, 0, t, e);

    // Default instruction after reset is IDCODE.
    scan_dr(32, 64'($urandom), 1'b0);

    // BYPASS delay.
    scan_ir(4'b0001);
    scan_dr(8, 64'(8'b0011_1100), 1'b0);

    // IDCODE.
    scan_ir(4'b0010);
    scan_dr(32, 64'($urandom), 1'b0);

    // CONFIG without sync word, then sync + data.
    scan_ir(4'b0100);
    scan_dr(8, 64'(8'hA4), 1'b0);
    scan_dr(8, 64'(8'hF0), 1'b0);
    scan_dr(8, 64'(8'h01), 1'b0);
    chk("cfg_after_write", 64'(oCfgData), 64'(8'h01));

    // Desync then data: no write.
    tick(0, 0, 1, t, e); m_flag = 1'b0;
    scan_dr(8, 64'(8'h55), 1'b0);

    // Desync coincident with Update-DR.
    scan_dr(8, 64'(8'hF0), 1'b0);
    scan_dr(8, 64'(8'h77), 1'b1);

    // Full-range sync/write loop.
    for (int v = 1; v < 256; v++) begin
      tick(0, 0, 1, t, e); m_flag = 1'b0;
      scan_dr(8, 64'(8'hF0), 1'b0);
      scan_dr(8, 64'(v), 1'b0);
    end

    // Five TMS highs from Shift-DR with sync set.
    scan_dr(8, 64'(8'hF0), 1'b0);
    tms5_from_shift(2'b10);
    scan_dr(32, 64'($urandom), 1'b0);
    scan_ir(4'b0100);
    scan_dr(8, 64'(8'h33), 1'b0);

    // Reset in the middle of a shift.
    scan_dr(8, 64'(8'hF0), 1'b0);
    tick(1, 0, 0, t, e); tick(0, 0, 0, t, e); tick(0, 0, 0, t, e);
    repeat (3) tick(0, 1, 0, t, e);
    iTrst = 1'b1;
    tick(0, 1, 0, t, e);
    iTrst = 1'b0;
    model_reset();
    tick(0, 0, 0, t, e);
    chk("midrst_tdo_en", 64'({t, e}), 64'(0));
    chk("midrst_cfg", 64'(oCfgData), 64'(0));
    chk("midrst_wr", 64'(oWrEn), 64'(0));
    scan_dr(32, 64'($urandom), 1'b0);

    // Randomized operations.
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        op = 4'($urandom);
        scan_ir(op);
      end else if (r == 2) begin
        scan_ir(4'b0100);
      end else if (r < 7) begin
        len = $urandom_range(1, 40);
        din = {32'($urandom), 32'($urandom)};
        if (m_instr == 4'b0100 && $urandom_range(0, 1) == 1) begin
          len = 8; din = 64'(8'hF0);
        end
        scan_dr(len, din, $urandom_range(0, 7) == 0);
      end else if (r == 7) begin
        tick(0, 0, 1, t, e); m_flag = 1'b0;
      end else if (r == 8) begin
        repeat (5) tick(1, 0, 0, t, e);
        m_instr = 4'b0010; m_flag = 1'b0;
        tick(0, 0, 0, t, e);
        chk("rand_tlr_out", 64'({t, e}), 64'(0));
      end else begin
        scan_dr(8, 64'($urandom_range(0, 255)), 1'b0);
      end
    end

    tick(0, 0, 0, t, e);
    chk("strobe_count", 64'(obs_strobes), 64'(m_strobes));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
